mem_scan_ctrl: RTL and testbench

Sequencing initiator for the 16x4 word memory. It drives the memory's address, write-data and read/write lines. It has two operations: a load operation streams 16 nibbles from an upstream source into memory using a valid/ready handshake, and a scan operation reads all 16 words in order and reports the greatest value and its address. It sits between the user datapath and the memory, and replaces direct switch-driven addressing.

---
 rtl/mem_scan_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_scan_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_scan_ctrl.sv
// Sequencing initiator for a DEPTH x WIDTH word memory: streams a full load in over
// a valid/ready handshake, or scans every word and reports the greatest value and its address.
module mem_scan_ctrl #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_load_i,
  input  logic              start_scan_i,
  input  logic [WIDTH-1:0]  din_i,
  input  logic              din_valid_i,
  output logic              din_ready_o,
  output logic [ADDR_W-1:0] mem_adrs_o,
  output logic [WIDTH-1:0]  mem_wdata_o,
  output logic              mem_rw_o,
  input  logic [WIDTH-1:0]  mem_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [WIDTH-1:0]  max_val_o,
  output logic [ADDR_W-1:0] max_adrs_o
);

  localparam logic [ADDR_W-1:0] LastAdrs = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StScan, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]    run_max_q, run_max_d;
  logic [ADDR_W-1:0]   run_adrs_q, run_adrs_d;
  logic [WIDTH-1:0]    max_val_q, max_val_d;
  logic [ADDR_W-1:0]   max_adrs_q, max_adrs_d;

  // Running result including the word read this cycle; >= lets later addresses win ties.
  logic                take_word;
  logic [WIDTH-1:0]    scan_max;
  logic [ADDR_W-1:0]   scan_adrs;

  always_comb begin
    take_word = (mem_rdata_i >= run_max_q);
    scan_max  = take_word ? mem_rdata_i : run_max_q;
    scan_adrs = take_word ? cnt_q : run_adrs_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_max_d   = run_max_q;
    run_adrs_d  = run_adrs_q;
    max_val_d   = max_val_q;
    max_adrs_d  = max_adrs_q;
    din_ready_o = 1'b0;
    mem_adrs_o  = '0;
    mem_wdata_o = '0;
    mem_rw_o    = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start_scan_i) begin
          state_d    = StScan;
          cnt_d      = '0;
          run_max_d  = '0;
          run_adrs_d = '0;
        end else if (start_load_i) begin
          state_d = StLoad;
          cnt_d   = '0;
        end
      end
      StLoad: begin
        din_ready_o = 1'b1;
        mem_adrs_o  = cnt_q;
        // Write strobe follows din_valid combinationally so stall cycles never write.
        mem_rw_o    = ~din_valid_i;
        if (din_valid_i) begin
          mem_wdata_o = din_i;
          cnt_d       = cnt_q + ADDR_W'(1);
          if (cnt_q == LastAdrs) state_d = StDone;
        end
      end
      StScan: begin
        mem_adrs_o = cnt_q;
        cnt_d      = cnt_q + ADDR_W'(1);
        run_max_d  = scan_max;
        run_adrs_d = scan_adrs;
        if (cnt_q == LastAdrs) begin
          state_d    = StDone;
          max_val_d  = scan_max;
          max_adrs_d = scan_adrs;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      run_max_q  <= '0;
      run_adrs_q <= '0;
      max_val_q  <= '0;
      max_adrs_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      run_max_q  <= run_max_d;
      run_adrs_q <= run_adrs_d;
      max_val_q  <= max_val_d;
      max_adrs_q <= max_adrs_d;
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign done_o     = (state_q == StDone);
  assign max_val_o  = max_val_q;
  assign max_adrs_o = max_adrs_q;

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Bench for mem_scan_ctrl: hosts a 16x4 memory, drives loads and scans with random data
// and stalls, and checks against a reference memory and a reference max search.
module tb_mem_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_load, start_scan, din_valid;
  logic       din_ready, mem_rw, busy, done;
  logic [3:0] din, mem_adrs, mem_wdata, mem_rdata, max_val, max_adrs;

  logic [3:0] mem      [16];
  logic [3:0] ref_mem  [16];
  logic [3:0] load_buf [16];
  logic [3:0] exp_val, exp_adrs;
  logic [7:0] wr_exp   [$];
  logic [7:0] wr_e;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  mem_scan_ctrl #(.DEPTH(16), .WIDTH(4), .ADDR_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_load_i (start_load),
    .start_scan_i (start_scan),
    .din_i        (din),
    .din_valid_i  (din_valid),
    .din_ready_o  (din_ready),
    .mem_adrs_o   (mem_adrs),
    .mem_wdata_o  (mem_wdata),
    .mem_rw_o     (mem_rw),
    .mem_rdata_i  (mem_rdata),
    .busy_o       (busy),
    .done_o       (done),
    .max_val_o    (max_val),
    .max_adrs_o   (max_adrs)
  );

  // The memory the controller drives: combinational read, write while mem_rw is low.
  assign mem_rdata = mem[mem_adrs];
  always @(posedge clk) if (!mem_rw) mem[mem_adrs] <= mem_wdata;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Each write must match exactly one handshake the bench drove in this cycle.
  always @(negedge clk) begin
    if (rst_n && !mem_rw) begin
      check_val("wr_pending", wr_exp.size(), 1);
      if (wr_exp.size() != 0) begin
        wr_e = wr_exp.pop_front();
        check_val("wr_adrs", mem_adrs, wr_e[7:4]);
        check_val("wr_data", mem_wdata, wr_e[3:0]);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_ready"}, din_ready, 0);
    check_val({tag, "_rw"}, mem_rw, 1);
    check_val({tag, "_adrs"}, mem_adrs, 0);
    check_val({tag, "_wdata"}, mem_wdata, 0);
    check_val({tag, "_max_val"}, max_val, 0);
    check_val({tag, "_max_adrs"}, max_adrs, 0);
  endtask

  // Called at posedge+1; drops reset mid-cycle and checks outputs before any edge.
  task automatic reset_midcycle();
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    exp_val = '0;
    exp_adrs = '0;
    wr_exp.delete();
    start_load = 0; start_scan = 0; din_valid = 0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic do_load(input bit stall, input int abort_at);
    start_load = 1;
    @(posedge clk); #1;
    start_load = 0;
    check_val("load_busy", busy, 1);
    for (int i = 0; i < 16; i++) begin
      if (stall) begin
        repeat ($urandom_range(0, 2)) begin
          din_valid = 0;
          din = 4'($urandom);
          @(negedge clk);
          check_val("stall_rw", mem_rw, 1);
          check_val("stall_wdata", mem_wdata, 0);
          @(posedge clk); #1;
        end
      end
      check_val("load_ready", din_ready, 1);
      check_val("load_adrs", mem_adrs, i);
      din = load_buf[i];
      din_valid = 1;
      wr_exp.push_back({4'(i), load_buf[i]});
      if (i == abort_at) begin
        reset_midcycle();
        return;
      end
      @(posedge clk); #1;
      ref_mem[i] = load_buf[i];
    end
    din_valid = 0;
    check_val("load_done", done, 1);
    check_val("load_done_busy", busy, 1);
    check_val("load_all_written", wr_exp.size(), 0);
    @(posedge clk); #1;
    check_val("load_done_pulse", done, 0);
    check_val("load_idle_busy", busy, 0);
    check_val("load_idle_ready", din_ready, 0);
    check_val("load_keeps_max_val", max_val, exp_val);
    check_val("load_keeps_max_adrs", max_adrs, exp_adrs);
  endtask

  task automatic do_scan(input bit with_load, input int abort_at);
    logic [3:0] best, idx;
    int seen;
    best = '0;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (ref_mem[i] >= best) begin
        best = ref_mem[i];
        idx = 4'(i);
      end
    end
    start_scan = 1;
    start_load = with_load;
    @(posedge clk); #1;
    start_scan = 0;
    start_load = 0;
    for (int c = 0; c < 16; c++) begin
      check_val("scan_adrs", mem_adrs, c);
      check_val("scan_rw", mem_rw, 1);
      check_val("scan_busy", busy, 1);
      check_val("scan_hold_val", max_val, exp_val);
      if (c == abort_at) begin
        reset_midcycle();
        seen = 0;
        repeat (20) begin
          if (done) seen++;
          @(posedge clk); #1;
        end
        check_val("abort_no_done", seen, 0);
        check_val("abort_max_val", max_val, 0);
        return;
      end
      start_load = (c == 5);
      @(posedge clk); #1;
    end
    start_load = 0;
    exp_val = best;
    exp_adrs = idx;
    check_val("scan_done", done, 1);
    check_val("scan_max_val", max_val, exp_val);
    check_val("scan_max_adrs", max_adrs, exp_adrs);
    check_val("scan_done_ready", din_ready, 0);
    start_load = 1;
    @(posedge clk); #1;
    start_load = 0;
    check_val("scan_done_pulse", done, 0);
    check_val("scan_idle_busy", busy, 0);
    check_val("scan_hold_adrs", max_adrs, exp_adrs);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 16; i++) check_val(tag, mem[i], ref_mem[i]);
  endtask

  initial begin
    logic [3:0] vec [16];
    vec = '{4'd1, 4'd3, 4'd9, 4'd7, 4'd8, 4'd12, 4'd5, 4'd0,
            4'd1, 4'd7, 4'd9, 4'd14, 4'd2, 4'd15, 4'd1, 4'd0};
    start_load = 0; start_scan = 0; din_valid = 0; din = '0;
    exp_val = '0; exp_adrs = '0;
    #2;
    check_reset_outputs("rst_init");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    load_buf = vec;
    do_load(0, -1);
    do_scan(0, -1);
    check_val("vec_max_val", max_val, 15);
    check_val("vec_max_adrs", max_adrs, 13);

    for (int i = 0; i < 16; i++) load_buf[i] = 4'd5;
    do_load(0, -1);
    do_scan(0, -1);
    check_val("fives_max_adrs", max_adrs, 15);

    for (int i = 0; i < 16; i++) load_buf[i] = 4'd0;
    do_load(0, -1);
    do_scan(0, -1);
    check_val("zeros_max_adrs", max_adrs, 15);

    for (int i = 0; i < 16; i++) load_buf[i] = 4'($urandom);
    do_load(1, -1);
    check_mem("stall_mem");
    do_scan(1, -1);

    do_scan(0, 7);
    do_scan(0, -1);

    for (int i = 0; i < 16; i++) load_buf[i] = 4'($urandom);
    do_load(0, 9);
    repeat (3) begin
      check_val("abort_load_rw", mem_rw, 1);
      @(posedge clk); #1;
    end
    check_mem("abort_load_mem");
    do_scan(0, -1);

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 16; i++)
        load_buf[i] = 4'($urandom_range(0, (it % 2 == 0) ? 3 : 15));
      do_load(it % 3 != 0, -1);
      check_mem("rand_mem");
      do_scan(0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
